// File: rtl/ecc_pmul_pkg.sv
// Shared types and constants for the P-256 point-multiplier result capture block.
// FSM state encoding, error codes and default geometry of the result words.
package ecc_pmul_pkg;

   localparam int P_WORDS  = 8;
   localparam int P_WORD_W = 32;

   // ST_ZERO is only reachable when the zeroize build option is enabled.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ZERO  = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE       = 2'd0;
   localparam logic [1:0] ERR_INCOMPLETE = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
   localparam logic [1:0] ERR_RESTART    = 2'd3;

endpackage

// File: rtl/ecc_word_bank.sv
// One coordinate of result storage: pWORDS x pWORD_W words with a write port,
// a single-word clear port and a registered byte-wide read port.
module ecc_word_bank
   import ecc_pmul_pkg::*;
#(
   parameter int pWORDS  = P_WORDS,
   parameter int pWORD_W = P_WORD_W,
   parameter int ADDR_W  = $clog2(pWORDS),
   parameter int BSEL_W  = $clog2(pWORD_W / 8)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  logic [ADDR_W-1:0]          wr_addr_i,
   input  logic [pWORD_W-1:0]         wr_data_i,
   input  logic                       clr_en_i,
   input  logic [ADDR_W-1:0]          clr_addr_i,
   input  logic [ADDR_W+BSEL_W-1:0]   rd_byte_i,
   output logic [7:0]                 rd_data_o
);

   logic [pWORD_W-1:0] mem_q [pWORDS];
   logic [pWORD_W-1:0] mem_d [pWORDS];
   logic [pWORD_W-1:0] rd_word;
   logic [7:0]         rd_data_d;
   logic [7:0]         rd_data_q;

   always_comb begin
      for (int i = 0; i < pWORDS; i++) begin
         mem_d[i] = mem_q[i];
         if (clr_en_i && (clr_addr_i == ADDR_W'(i))) mem_d[i] = '0;
         if (wr_en_i && (wr_addr_i == ADDR_W'(i)))   mem_d[i] = wr_data_i;
      end
      rd_word   = mem_q[rd_byte_i[ADDR_W+BSEL_W-1:BSEL_W]];
      rd_data_d = rd_word[{rd_byte_i[BSEL_W-1:0], 3'b000} +: 8];
   end

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ecc_pmul_result_capture.sv
// Captures the affine x/y result words of curve_mul_256, tracks completion,
// errors and timeout, and serves the result byte-wise. Option: ECC_RESULT_ZEROIZE_EN.
module ecc_pmul_result_capture
   import ecc_pmul_pkg::*;
#(
   parameter int pWORDS     = P_WORDS,
   parameter int pWORD_W    = P_WORD_W,
   parameter int pTIMEOUT_W = 24
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start_i,
   input  logic                                 core_rdy_i,
   input  logic [$clog2(pWORDS)-1:0]            rx_addr_i,
   input  logic                                 rx_wren_i,
   input  logic [pWORD_W-1:0]                   rx_din_i,
   input  logic [$clog2(pWORDS)-1:0]            ry_addr_i,
   input  logic                                 ry_wren_i,
   input  logic [pWORD_W-1:0]                   ry_din_i,
   input  logic                                 rd_sel_i,
   input  logic [$clog2(pWORDS*pWORD_W/8)-1:0]  rd_byte_i,
   output logic [7:0]                           rd_data_o,
   output logic [2*pWORDS-1:0]                  word_mask_o,
   output logic                                 valid_o,
   output logic                                 err_o,
   output logic [1:0]                           err_code_o,
   output logic                                 busy_o
);

   localparam int ADDR_W = $clog2(pWORDS);

   state_e                state_q, state_d;
   logic [2*pWORDS-1:0]   mask_q, mask_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;
   logic [pTIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
   logic                  rdy_q, rd_sel_q;
   logic                  x_we, y_we, rdy_rise, wd_sat, armed_go, clr_en;
   logic [ADDR_W-1:0]     clr_addr;
   logic [pWORDS-1:0]     x_hit, y_hit;
   logic [7:0]            x_byte, y_byte;
`ifdef ECC_RESULT_ZEROIZE_EN
   logic [ADDR_W-1:0]     zcnt_q, zcnt_d;
   logic                  fell_q, fell_d;
`endif

   always_comb begin
      x_we     = (state_q == ST_RUN) && rx_wren_i;
      y_we     = (state_q == ST_RUN) && ry_wren_i;
      x_hit    = '0;
      y_hit    = '0;
      if (x_we) x_hit[rx_addr_i] = 1'b1;
      if (y_we) y_hit[ry_addr_i] = 1'b1;
      rdy_rise = core_rdy_i && !rdy_q;
      wd_inc   = wd_q + 1'b1;
      wd_sat   = &wd_inc;
`ifdef ECC_RESULT_ZEROIZE_EN
      armed_go = !core_rdy_i || fell_q;
      zcnt_d   = zcnt_q;
      fell_d   = fell_q;
`else
      armed_go = !core_rdy_i;
`endif
      state_d  = state_q;
      mask_d   = mask_q;
      valid_d  = valid_q;
      err_d    = err_q;
      code_d   = code_q;
      wd_d     = wd_q;
      clr_en   = 1'b0;
      clr_addr = '0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               mask_d  = '0;
               valid_d = 1'b0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               wd_d    = '0;
`ifdef ECC_RESULT_ZEROIZE_EN
               state_d = ST_ZERO;
               zcnt_d  = '0;
               fell_d  = 1'b0;
`else
               state_d = ST_ARMED;
`endif
            end
         end
`ifdef ECC_RESULT_ZEROIZE_EN
         ST_ZERO: begin
            clr_en   = 1'b1;
            clr_addr = zcnt_q;
            zcnt_d   = zcnt_q + 1'b1;
            if (!core_rdy_i) fell_d = 1'b1;
            if (start_i) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_RESTART;
            end else if (zcnt_q == ADDR_W'(pWORDS - 1)) begin
               state_d = ST_ARMED;
            end
         end
`endif
         ST_ARMED: begin
            wd_d = wd_inc;
            if (start_i) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_RESTART;
            end else if (wd_sat) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end else if (armed_go) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Same-cycle writes count toward completion on the rdy rise.
            mask_d = mask_q | {y_hit, x_hit};
            wd_d   = wd_inc;
            if (start_i) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_RESTART;
            end else if (rdy_rise) begin
               if (&mask_d) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_INCOMPLETE;
               end
            end else if (wd_sat) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
         wd_q     <= '0;
         rdy_q    <= 1'b1;
         rd_sel_q <= 1'b0;
`ifdef ECC_RESULT_ZEROIZE_EN
         zcnt_q   <= '0;
         fell_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         code_q   <= code_d;
         wd_q     <= wd_d;
         rdy_q    <= core_rdy_i;
         rd_sel_q <= rd_sel_i;
`ifdef ECC_RESULT_ZEROIZE_EN
         zcnt_q   <= zcnt_d;
         fell_q   <= fell_d;
`endif
      end
   end

   ecc_word_bank #(.pWORDS(pWORDS), .pWORD_W(pWORD_W)) u_x_bank (
      .clk(clk), .rst_n(rst_n),
      .wr_en_i(x_we), .wr_addr_i(rx_addr_i), .wr_data_i(rx_din_i),
      .clr_en_i(clr_en), .clr_addr_i(clr_addr),
      .rd_byte_i(rd_byte_i), .rd_data_o(x_byte)
   );

   ecc_word_bank #(.pWORDS(pWORDS), .pWORD_W(pWORD_W)) u_y_bank (
      .clk(clk), .rst_n(rst_n),
      .wr_en_i(y_we), .wr_addr_i(ry_addr_i), .wr_data_i(ry_din_i),
      .clr_en_i(clr_en), .clr_addr_i(clr_addr),
      .rd_byte_i(rd_byte_i), .rd_data_o(y_byte)
   );

   // Both banks register the byte; the select is registered alongside it.
   assign rd_data_o   = rd_sel_q ? y_byte : x_byte;
   assign word_mask_o = mask_q;
   assign valid_o     = valid_q;
   assign err_o       = err_q;
   assign err_code_o  = code_q;
   assign busy_o      = (state_q == ST_ARMED) || (state_q == ST_RUN) || (state_q == ST_ZERO);

endmodule

// File: tb/tb_ecc_pmul_result_capture.sv
// Directed bench for ecc_pmul_result_capture: status and readback expectations
// are queued by the driver and popped by monitors sampling on the falling edge.
module tb_ecc_pmul_result_capture;

`ifdef ECC_RESULT_ZEROIZE_EN
   localparam int ZD = 8;
`else
   localparam int ZD = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, core_rdy_i;
   logic [2:0]  rx_addr_i, ry_addr_i;
   logic        rx_wren_i, ry_wren_i;
   logic [31:0] rx_din_i, ry_din_i;
   logic        rd_sel_i;
   logic [4:0]  rd_byte_i;
   logic [7:0]  rd_data_o, w_rd_data_o;
   logic [15:0] word_mask_o, w_word_mask_o;
   logic        valid_o, err_o, busy_o, w_valid_o, w_err_o, w_busy_o;
   logic [1:0]  err_code_o, w_err_code_o;
   logic        w_start_i, w_core_rdy_i, w_rx_wren_i;

   logic [21:0] st_q[$];
   logic [7:0]  rd_q[$];
   logic        st_pend = 1'b0;
   logic        rd_pend = 1'b0;
   logic        rd_seen = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ecc_pmul_result_capture dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .core_rdy_i(core_rdy_i),
      .rx_addr_i(rx_addr_i), .rx_wren_i(rx_wren_i), .rx_din_i(rx_din_i),
      .ry_addr_i(ry_addr_i), .ry_wren_i(ry_wren_i), .ry_din_i(ry_din_i),
      .rd_sel_i(rd_sel_i), .rd_byte_i(rd_byte_i), .rd_data_o(rd_data_o),
      .word_mask_o(word_mask_o), .valid_o(valid_o), .err_o(err_o),
      .err_code_o(err_code_o), .busy_o(busy_o)
   );

   ecc_pmul_result_capture #(.pTIMEOUT_W(4)) dut_wd (
      .clk(clk), .rst_n(rst_n), .start_i(w_start_i), .core_rdy_i(w_core_rdy_i),
      .rx_addr_i(rx_addr_i), .rx_wren_i(w_rx_wren_i), .rx_din_i(rx_din_i),
      .ry_addr_i(ry_addr_i), .ry_wren_i(1'b0), .ry_din_i(ry_din_i),
      .rd_sel_i(rd_sel_i), .rd_byte_i(rd_byte_i), .rd_data_o(w_rd_data_o),
      .word_mask_o(w_word_mask_o), .valid_o(w_valid_o), .err_o(w_err_o),
      .err_code_o(w_err_code_o), .busy_o(w_busy_o)
   );

   // ---------------- monitors ----------------
   always @(posedge clk) rd_seen <= rd_pend;

   always @(negedge clk) begin
      logic [21:0] exp_s, act_s;
      logic [7:0]  exp_b;
      if (st_pend) begin
         checks++;
         if (st_q.size() == 0) begin
            errors++;
            $display("FAIL status: no expected entry queued");
         end else begin
            exp_s = st_q.pop_front();
            act_s = exp_s[21] ? {1'b1, w_valid_o, w_err_o, w_err_code_o, w_busy_o, w_word_mask_o}
                              : {1'b0, valid_o, err_o, err_code_o, busy_o, word_mask_o};
            if (act_s !== exp_s) begin
               errors++;
               $display("FAIL status @%0t: got %h expected %h ({inst,valid,err,code,busy,mask})",
                        $time, act_s, exp_s);
            end
         end
      end
      if (rd_seen) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL readback: no expected entry queued");
         end else begin
            exp_b = rd_q.pop_front();
            if (rd_data_o !== exp_b) begin
               errors++;
               $display("FAIL readback @%0t: got %h expected %h", $time, rd_data_o, exp_b);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic st_chk(input logic inst, input logic v, input logic e, input logic [1:0] c,
                         input logic b, input logic [15:0] m);
      st_q.push_back({inst, v, e, c, b, m});
      st_pend = 1'b1;
      @(negedge clk);
      #1;
      st_pend = 1'b0;
   endtask

   task automatic rd_chk(input logic sel, input logic [4:0] idx, input logic [7:0] exp);
      rd_sel_i  = sel;
      rd_byte_i = idx;
      rd_q.push_back(exp);
      rd_pend = 1'b1;
      tick(1);
      rd_pend = 1'b0;
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic xv, input int xa, input logic [31:0] xd,
                     input logic yv, input int ya, input logic [31:0] yd, input logic rdy);
      rx_wren_i = xv; rx_addr_i = 3'(xa); rx_din_i = xd;
      ry_wren_i = yv; ry_addr_i = 3'(ya); ry_din_i = yd;
      core_rdy_i = rdy;
      tick(1);
      rx_wren_i = 1'b0;
      ry_wren_i = 1'b0;
   endtask

   function automatic logic [31:0] xv1(input int i);
      return 32'(32'h1111_1111 * (i + 1));
   endfunction

   function automatic logic [31:0] yv1(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   task automatic run_begin();
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      tick(2);
      core_rdy_i = 1'b0;
      tick(1 + ZD);
   endtask

   task automatic full_run();
      run_begin();
      for (int i = 0; i < 8; i++) wr(1'b1, i, xv1(i), 1'b0, 0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) wr(1'b0, 0, 32'h0, 1'b1, i, yv1(i), 1'b0);
      core_rdy_i = 1'b1;
      tick(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      start_i = 1'b0; core_rdy_i = 1'b1;
      rx_addr_i = '0; rx_wren_i = 1'b0; rx_din_i = '0;
      ry_addr_i = '0; ry_wren_i = 1'b0; ry_din_i = '0;
      rd_sel_i = 1'b0; rd_byte_i = '0;
      w_start_i = 1'b0; w_core_rdy_i = 1'b1; w_rx_wren_i = 1'b0;
      tick(3);
      st_chk(1'b0, 0, 0, 2'd0, 0, 16'h0000);
      chk8("reset rd_data", rd_data_o, 8'h00);
      tick(1);
      st_chk(1'b1, 0, 0, 2'd0, 0, 16'h0000);
      rst_n = 1'b1;
      tick(1);

      // Normal run, then a write in DONE that must be ignored.
      full_run();
      st_chk(1'b0, 1, 0, 2'd0, 0, 16'hFFFF);
      rd_chk(1'b0, 5'd4,  8'h22);
      rd_chk(1'b1, 5'd31, 8'hA0);
      rd_chk(1'b1, 5'd28, 8'h07);
      rd_chk(1'b0, 5'd0,  8'h11);
      rd_chk(1'b0, 5'd31, 8'h88);
      wr(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b1);
      rd_chk(1'b0, 5'd12, 8'h44);
      st_chk(1'b0, 1, 0, 2'd0, 0, 16'hFFFF);

      // Paired x/y writes, last pair coinciding with the rdy rise.
      run_begin();
      st_chk(1'b0, 0, 0, 2'd0, 1, 16'h0000);
      for (int i = 0; i < 8; i++)
         wr(1'b1, i, 32'hC0DE_0000 + 32'(i), 1'b1, i, 32'h0000_BEE0 + 32'(i), (i == 7));
      st_chk(1'b0, 1, 0, 2'd0, 0, 16'hFFFF);
      rd_chk(1'b0, 5'd31, 8'hC0);
      rd_chk(1'b0, 5'd28, 8'h07);
      rd_chk(1'b1, 5'd29, 8'hBE);
      rd_chk(1'b1, 5'd0,  8'hE0);

      // y word 5 missing.
      run_begin();
      for (int i = 0; i < 8; i++) wr(1'b1, i, xv1(i), (i != 5), i, yv1(i), 1'b0);
      core_rdy_i = 1'b1;
      tick(1);
      st_chk(1'b0, 0, 1, 2'd1, 0, 16'hDFFF);
`ifdef ECC_RESULT_ZEROIZE_EN
      rd_chk(1'b1, 5'd20, 8'h00);
`else
      rd_chk(1'b1, 5'd20, 8'hE5);
`endif

      // Watchdog on the 4-bit instance: timeout 15 counting cycles after start.
      w_core_rdy_i = 1'b0;
      w_start_i = 1'b1;
      tick(1);
      w_start_i = 1'b0;
      tick(1 + ZD);
      rx_addr_i = 3'd0; rx_din_i = 32'h0BAD_F00D; w_rx_wren_i = 1'b1;
      tick(1);
      w_rx_wren_i = 1'b0;
      tick(12);
      st_chk(1'b1, 0, 0, 2'd0, 1, 16'h0001);
      tick(1);
      st_chk(1'b1, 0, 1, 2'd2, 0, 16'h0001);
      rx_addr_i = 3'd1; w_rx_wren_i = 1'b1;
      tick(1);
      w_rx_wren_i = 1'b0;
      st_chk(1'b1, 0, 1, 2'd2, 0, 16'h0001);

      // start_i during RUN, then a clean run from ERR.
      run_begin();
      wr(1'b1, 0, 32'h5555_0000, 1'b0, 0, 32'h0, 1'b0);
      wr(1'b1, 1, 32'h5555_0001, 1'b0, 0, 32'h0, 1'b0);
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      st_chk(1'b0, 0, 1, 2'd3, 0, 16'h0003);
      core_rdy_i = 1'b1;
      tick(1);
      full_run();
      st_chk(1'b0, 1, 0, 2'd0, 0, 16'hFFFF);

      // Reset in the middle of a run.
      run_begin();
      wr(1'b1, 0, 32'h1234_5678, 1'b0, 0, 32'h0, 1'b0);
      rst_n = 1'b0;
      st_chk(1'b0, 0, 0, 2'd0, 0, 16'h0000);
      chk8("mid-run reset rd_data", rd_data_o, 8'h00);
      core_rdy_i = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      run_begin();
      wr(1'b1, 0, 32'h0000_0055, 1'b0, 0, 32'h0, 1'b0);
      core_rdy_i = 1'b1;
      tick(1);
      st_chk(1'b0, 0, 1, 2'd1, 0, 16'h0001);
`ifdef ECC_RESULT_ZEROIZE_EN
      rd_chk(1'b0, 5'd8, 8'h00);
`else
      rd_chk(1'b0, 5'd8, 8'h33);
`endif
      rd_chk(1'b0, 5'd0, 8'h55);

      for (int i = 0; i < 20 && (st_q.size() != 0 || rd_q.size() != 0 || rd_seen); i++)
         @(negedge clk);
      #1;
      checks++;
      if (st_q.size() != 0 || rd_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d status and %0d readback entries left, expected 0",
                  st_q.size(), rd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish within bound");
      $fatal(1);
   end

endmodule
